// File: rtl/rr_arb8_sel.sv
// rtl/rr_arb8_sel.sv - round-robin arbiter driving the 8-way selector select and grants
// Optional hold-timeout preemption is compiled in with `define ARB_TIMEOUT_EN.
module rr_arb8_sel #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] req_i,
  output logic [7:0] gnt_o,
  output logic [2:0] sel_o,
  output logic       busy_o,
  output logic       preempt_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] last_q, last_d;

  logic [2:0] win_idx;
  logic       win_vld;
  logic [2:0] cand;
  logic       take;

  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_max_hold_check
    $error("rr_arb8_sel: MAX_HOLD must be in 1..15");
  end

  // Scan last+8 down to last+1 so the nearest requester after last wins; last itself ranks lowest.
  always_comb begin
    win_idx = last_q;
    win_vld = 1'b0;
    cand    = last_q;
    for (int i = 8; i >= 1; i--) begin
      cand = last_q + 3'(i);
      if (req_i[cand]) begin
        win_idx = cand;
        win_vld = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  logic [3:0] hold_q, hold_d;
  logic       preempt_q, preempt_d;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    take    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    preempt_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_vld) take = 1'b1;
      end
      ST_GRANT: begin
        if (!req_i[sel_q]) begin
          if (win_vld) begin
            take = 1'b1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 8'h00;
          end
        end
`ifdef ARB_TIMEOUT_EN
        // Owner still requesting: the winner differs from it only when someone else is waiting.
        else if (hold_q == HOLD_LAST && win_idx != sel_q) begin
          take      = 1'b1;
          preempt_d = 1'b1;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 8'h00;
      end
    endcase
    if (take) begin
      state_d = ST_GRANT;
      gnt_d   = 8'b1 << win_idx;
      sel_d   = win_idx;
      last_d  = win_idx;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_comb begin
    hold_d = hold_q;
    if (take || state_d == ST_IDLE) begin
      hold_d = 4'd0;
    end else if (state_q == ST_GRANT && hold_q != HOLD_LAST) begin
      hold_d = hold_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q    <= 4'd0;
      preempt_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign preempt_o = preempt_q;
`else
  assign preempt_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      gnt_q   <= 8'h00;
      sel_q   <= 3'd0;
      last_q  <= 3'd7;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign sel_o  = sel_q;
  assign busy_o = (state_q == ST_GRANT);

endmodule

// File: tb/tb_rr_arb8_sel.sv
// tb/tb_rr_arb8_sel.sv - directed self-checking bench for rr_arb8_sel
// Timeout expectations follow `define ARB_TIMEOUT_EN, matching the design build.
module tb_rr_arb8_sel;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       preempt;

  int n_vec;
  int n_err;

  rr_arb8_sel #(.MAX_HOLD(4)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (req),
    .gnt_o     (gnt),
    .sel_o     (sel),
    .busy_o    (busy),
    .preempt_o (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_sel,
                         input logic e_busy);
    chk({tag, " gnt"},  gnt,          e_gnt);
    chk({tag, " sel"},  {5'd0, sel},  {5'd0, e_sel});
    chk({tag, " busy"}, {7'd0, busy}, {7'd0, e_busy});
  endtask

  task automatic rst_pulse();
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 8'h00, 3'd0, 1'b0);
    chk("async_rst preempt", {7'd0, preempt}, 8'h00);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] own;
    logic [7:0] e_g;
    logic       e_p;
    n_vec = 0;
    n_err = 0;

    rst_n = 1'b0;
    req   = 8'hFF;
    #1;
    chk_out("reset t0", 8'h00, 3'd0, 1'b0);
    chk("reset t0 preempt", {7'd0, preempt}, 8'h00);
    tick();
    tick();
    chk_out("reset held", 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_out("post_reset", 8'h01, 3'd0, 1'b1);
    req = 8'h00;
    tick();
    chk_out("drop_to_idle", 8'h00, 3'd0, 1'b0);

    req = 8'h08;
    tick();
    chk_out("single grant", 8'h08, 3'd3, 1'b1);
    tick();
    tick();
    tick();
    chk_out("single hold", 8'h08, 3'd3, 1'b1);
    req = 8'h00;
    tick();
    chk_out("single release", 8'h00, 3'd3, 1'b0);

    rst_pulse();
    req = 8'hFF;
    tick();
    for (int k = 0; k < 9; k++) begin
      own = 3'(k);
      chk_out("rot first", 8'b1 << own, own, 1'b1);
      tick();
      chk_out("rot second", 8'b1 << own, own, 1'b1);
      req[own] = 1'b0;
      tick();
      req[own] = 1'b1;
    end
    chk_out("rot after", 8'h02, 3'd1, 1'b1);
    req = 8'h00;
    tick();
    chk_out("rot idle", 8'h00, 3'd1, 1'b0);

    req = 8'h04;
    tick();
    chk_out("handoff own2", 8'h04, 3'd2, 1'b1);
    req = 8'h24;
    tick();
    chk_out("handoff pending", 8'h04, 3'd2, 1'b1);
    req = 8'h20;
    tick();
    chk_out("handoff to5", 8'h20, 3'd5, 1'b1);
    req = 8'h00;
    tick();
    chk_out("handoff idle", 8'h00, 3'd5, 1'b0);

    req = 8'h41;
    tick();
    chk_out("same_edge", 8'h40, 3'd6, 1'b1);
    req = 8'h40;
    tick();
    req = 8'h00;
    tick();
    chk_out("withdrawn never granted", 8'h00, 3'd6, 1'b0);
    req = 8'h01;
    tick();
    chk_out("wrap to0", 8'h01, 3'd0, 1'b1);
    req = 8'h00;
    tick();

    req = 8'h40;
    tick();
    chk_out("owner6", 8'h40, 3'd6, 1'b1);
    rst_pulse();
    req = 8'hC1;
    tick();
    chk_out("after_rst C1", 8'h01, 3'd0, 1'b1);
    req = 8'h00;
    tick();

    rst_pulse();
    req = 8'h03;
    for (int i = 1; i <= 9; i++) begin
      tick();
`ifdef ARB_TIMEOUT_EN
      e_g = (i <= 4) ? 8'h01 : ((i <= 8) ? 8'h02 : 8'h01);
      e_p = (i == 5) || (i == 9);
`else
      e_g = 8'h01;
      e_p = 1'b0;
`endif
      chk("timeout gnt", gnt, e_g);
      chk("timeout preempt", {7'd0, preempt}, {7'd0, e_p});
    end
    req = 8'h00;
    tick();
    chk_out("final idle", 8'h00, sel, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
